// File: rtl/fpu_issue_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : fpu_issue_scheduler                                      |
// | Description : Issue sequencer for the shared, non-pipelined FPU.       |
// |               Tracks a per-register busy scoreboard over the 32 FP     |
// |               registers. Raises the ID stall on RAW/WAW hazards, on    |
// |               FPU structural conflicts and on write-port starvation.   |
// |               Arbitrates the FP regfile write port between the WB      |
// |               stage and the buffered FPU result.                       |
// | Option      : FPU_PERF_CNT_EN adds the perf_stall and perf_issue       |
// |               free-running counters.                                   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module fpu_issue_scheduler #(
  parameter int ADD_LAT       = 4,
  parameter int MUL_LAT       = 6,
  parameter int DIV_LAT       = 20,
  parameter int WB_STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_fpu_op,
  input  logic [1:0] id_op,
  input  logic [4:0] id_Fs,
  input  logic [4:0] id_Ft,
  input  logic [4:0] id_Fd,
  input  logic       id_use_Fs,
  input  logic       id_use_Ft,
  input  logic       id_def_Fd,
  input  logic       flush,
  input  logic       pipe_fp_write,
  input  logic [4:0] pipe_fp_dst,
  output logic       fpu_start,
  output logic [1:0] fpu_op,
  output logic       fpu_capture,
  output logic       wb_en,
  output logic       wb_sel,
  output logic [4:0] wb_dst,
  output logic       stall,
`ifdef FPU_PERF_CNT_EN
  output logic       fpu_busy,
  output logic [31:0] perf_stall,
  output logic [15:0] perf_issue
`else
  output logic       fpu_busy
`endif
);

  // Wait counter only needs to reach WB_STARVE_MAX, where it saturates.
  localparam int WAIT_W = (WB_STARVE_MAX < 2) ? 1 : $clog2(WB_STARVE_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WB_STARVE_MAX);

  // Counter preload is LAT-1 so fpu_capture lands exactly LAT cycles after fpu_start.
  localparam logic [5:0] ADD_CNT = 6'(ADD_LAT - 1);
  localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       busy_q, busy_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [4:0]        pend_dst_q, pend_dst_d;
  logic [1:0]        op_q, op_d;

  logic              starve;
  logic              haz;
  logic              issue;
  logic [5:0]        lat_cnt;

  // Hazard detection, stall generation and the issue condition.
  always_comb begin
    starve = (state_q == S_WB) && (wait_q >= WAIT_MAX);
    haz    = (id_use_Fs & busy_q[id_Fs])
           | (id_use_Ft & busy_q[id_Ft])
           | (id_def_Fd & busy_q[id_Fd])
           | (id_fpu_op & (state_q != S_IDLE))
           | starve;
    stall  = haz & ~flush;
    issue  = id_fpu_op & ~haz & ~flush & (state_q == S_IDLE);
  end

  // Latency preload selected by the ID op code; reserved op 3 is timed as an add.
  always_comb begin
    lat_cnt = ADD_CNT;
    case (id_op)
      2'd1:    lat_cnt = MUL_CNT;
      2'd2:    lat_cnt = DIV_CNT;
      default: lat_cnt = ADD_CNT;
    endcase
  end

  // Next-state logic, scoreboard updates and write-port arbitration.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    pend_dst_d  = pend_dst_q;
    op_d        = op_q;
    fpu_start   = 1'b0;
    fpu_op      = op_q;
    fpu_capture = 1'b0;
    wb_en       = pipe_fp_write;
    wb_sel      = 1'b0;
    wb_dst      = pipe_fp_dst;

    case (state_q)
      S_IDLE: begin
        if (issue) begin
          fpu_start         = 1'b1;
          fpu_op            = id_op;
          op_d              = id_op;
          pend_dst_d        = id_Fd;
          busy_d[id_Fd]     = 1'b1;
          cnt_d             = lat_cnt;
          state_d           = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q != 6'd0) begin
          cnt_d = cnt_q - 6'd1;
        end else begin
          fpu_capture = 1'b1;
          state_d     = S_WB;
        end
      end
      S_WB: begin
        // The pipeline keeps the port while it writes; the FPU result waits.
        if (pipe_fp_write) begin
          if (wait_q < WAIT_MAX) begin
            wait_d = wait_q + 1'b1;
          end
        end else begin
          wb_en              = 1'b1;
          wb_sel             = 1'b1;
          wb_dst             = pend_dst_q;
          busy_d[pend_dst_q] = 1'b0;
          wait_d             = '0;
          state_d            = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign fpu_busy = (state_q != S_IDLE);

  // State, scoreboard and counters; reset discards any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      busy_q     <= '0;
      cnt_q      <= '0;
      wait_q     <= '0;
      pend_dst_q <= '0;
      op_q       <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      pend_dst_q <= pend_dst_d;
      op_q       <= op_d;
    end
  end

`ifdef FPU_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [15:0] perf_issue_q, perf_issue_d;

  // Free-running, wrapping event counters.
  always_comb begin
    perf_stall_d = perf_stall_q + {31'd0, stall};
    perf_issue_d = perf_issue_q + {15'd0, fpu_start};
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_issue_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_issue_q <= perf_issue_d;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_issue = perf_issue_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_fpu_issue_scheduler                                   |
// | Description : Self-checking bench for fpu_issue_scheduler. A timeline  |
// |               model (start cycle + latency, busy array, wait count)    |
// |               predicts every output each cycle; directed scenarios     |
// |               are followed by randomized traffic.                      |
// | Option      : FPU_PERF_CNT_EN also checks the perf counters.           |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_fpu_issue_scheduler;
  localparam int ADD_LAT = 4;
  localparam int MUL_LAT = 6;
  localparam int DIV_LAT = 20;
  localparam int STARVE  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_fpu_op, id_use_Fs, id_use_Ft, id_def_Fd, flush, pipe_fp_write;
  logic [1:0] id_op;
  logic [4:0] id_Fs, id_Ft, id_Fd, pipe_fp_dst;
  logic       fpu_start, fpu_capture, wb_en, wb_sel, stall, fpu_busy;
  logic [1:0] fpu_op;
  logic [4:0] wb_dst;
`ifdef FPU_PERF_CNT_EN
  logic [31:0] perf_stall;
  logic [15:0] perf_issue;
`endif

  fpu_issue_scheduler #(
    .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .WB_STARVE_MAX(STARVE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_fpu_op(id_fpu_op), .id_op(id_op),
    .id_Fs(id_Fs), .id_Ft(id_Ft), .id_Fd(id_Fd),
    .id_use_Fs(id_use_Fs), .id_use_Ft(id_use_Ft), .id_def_Fd(id_def_Fd),
    .flush(flush), .pipe_fp_write(pipe_fp_write), .pipe_fp_dst(pipe_fp_dst),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_capture(fpu_capture),
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_dst(wb_dst), .stall(stall),
`ifdef FPU_PERF_CNT_EN
    .perf_stall(perf_stall), .perf_issue(perf_issue),
`endif
    .fpu_busy(fpu_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one in-flight op described by its start cycle and latency.
  bit m_busy[32];
  bit m_fly;
  int m_start, m_lat, m_dst, m_op, m_waits, cyc;
  int unsigned m_pstall, m_pissue;
  bit e_stall;
  bit obs_stall, obs_start, obs_cap, obs_wb_en, obs_wb_sel;
  logic [4:0] obs_wb_dst;

  function automatic int lat_of(input int op);
    if (op == 1) return MUL_LAT;
    if (op == 2) return DIV_LAT;
    return ADD_LAT;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_fly = 0; m_waits = 0; m_pstall = 0; m_pissue = 0; e_stall = 0;
  endtask

  task automatic clear_id();
    id_fpu_op = 0; id_op = 0; id_Fs = 0; id_Ft = 0; id_Fd = 0;
    id_use_Fs = 0; id_use_Ft = 0; id_def_Fd = 0; flush = 0;
    pipe_fp_write = 0; pipe_fp_dst = 0;
  endtask

  task automatic set_id(input bit f, input int op, input int fs, input int ft, input int fd,
                        input bit ufs, input bit uft, input bit dfd);
    id_fpu_op = f; id_op = 2'(op); id_Fs = 5'(fs); id_Ft = 5'(ft); id_Fd = 5'(fd);
    id_use_Fs = ufs; id_use_Ft = uft; id_def_Fd = dfd;
  endtask

  // One clock: predict and compare at the negedge, advance the model at the posedge.
  task automatic cycle();
    bit in_wb, starve, haz, issue, cap, ex_en, ex_sel;
    int ex_dst;
    @(negedge clk);
    in_wb  = m_fly && (cyc > m_start + m_lat);
    cap    = m_fly && (cyc == m_start + m_lat);
    starve = in_wb && (m_waits >= STARVE);
    haz    = (id_use_Fs && m_busy[id_Fs]) || (id_use_Ft && m_busy[id_Ft]) ||
             (id_def_Fd && m_busy[id_Fd]) || (id_fpu_op && m_fly) || starve;
    issue  = id_fpu_op && !haz && !flush && !m_fly;
    if (in_wb && !pipe_fp_write) begin
      ex_en = 1; ex_sel = 1; ex_dst = m_dst;
    end else begin
      ex_en = pipe_fp_write; ex_sel = 0; ex_dst = int'(pipe_fp_dst);
    end
    check("stall", stall, haz && !flush);
    check("fpu_start", fpu_start, issue);
    check("fpu_capture", fpu_capture, cap);
    check("fpu_busy", fpu_busy, m_fly);
    check("wb_en", wb_en, ex_en);
    check("wb_sel", wb_sel, ex_sel);
    check("wb_dst", wb_dst, 32'(ex_dst));
    if (issue) check("fpu_op_start", fpu_op, 32'(id_op));
    else if (m_fly && !in_wb) check("fpu_op_hold", fpu_op, 32'(m_op));
`ifdef FPU_PERF_CNT_EN
    check("perf_stall", perf_stall, m_pstall);
    check("perf_issue", perf_issue, 32'(m_pissue & 32'hFFFF));
`endif
    obs_stall = stall; obs_start = fpu_start; obs_cap = fpu_capture;
    obs_wb_en = wb_en; obs_wb_sel = wb_sel; obs_wb_dst = wb_dst;
    e_stall = haz && !flush;
    @(posedge clk);
    if (e_stall) m_pstall++;
    if (issue) m_pissue++;
    if (in_wb) begin
      if (pipe_fp_write) m_waits++;
      else begin
        m_busy[m_dst] = 0; m_fly = 0; m_waits = 0;
      end
    end
    if (issue) begin
      m_fly = 1; m_start = cyc; m_lat = lat_of(int'(id_op));
      m_dst = int'(id_Fd); m_op = int'(id_op); m_busy[id_Fd] = 1;
    end
    cyc++;
    #1;
  endtask

  task automatic drain();
    clear_id();
    for (int i = 0; i < 60; i++) begin
      if (!m_fly) break;
      cycle();
    end
    check("drain_idle", {31'd0, m_fly}, 0);
  endtask

  initial begin
    int n, first, k, cnt_sel, burst;
    clear_id();
    model_reset();
    cyc = 0;
    rst_n = 0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_stall", stall, 0);
    check("rst_busy", fpu_busy, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_fpu_op", fpu_op, 0);
    rst_n = 1;

    // Mul F2 <- F4*F6: capture 6 cycles after start, write one cycle later.
    set_id(1, 1, 4, 6, 2, 1, 1, 1);
    cycle();
    check("mul_start", obs_start, 1);
    clear_id();
    first = -1; k = -1; n = 0;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      if (obs_cap) first = i;
      if (obs_wb_en && obs_wb_sel) begin k = i; n = int'(obs_wb_dst); end
    end
    check("mul_capture_at", 32'(first), 6);
    check("mul_wb_at", 32'(k), 7);
    check("mul_wb_dst", 32'(n), 2);
    drain();

    // Add F1 then a reader of F1: stalled through the WB cycle.
    set_id(1, 0, 3, 4, 1, 1, 1, 1);
    cycle();
    set_id(0, 0, 1, 0, 0, 1, 0, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (!obs_stall) break;
      n++;
    end
    check("raw_stall_cycles", 32'(n), 5);
    drain();

    // Second FPU op behind a divide: 21 stalled cycles, issue on the 22nd.
    set_id(1, 2, 0, 0, 3, 0, 0, 1);
    cycle();
    set_id(1, 0, 8, 9, 10, 1, 1, 1);
    n = 0; k = -1;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (obs_stall) n++;
      if (obs_start) begin k = i; break; end
    end
    check("div_stall_cycles", 32'(n), 21);
    check("div_issue_at", 32'(k), 22);
    drain();

    // Write-port starvation: pipeline holds the port for 6 WB cycles.
    set_id(1, 0, 1, 2, 5, 1, 1, 1);
    cycle();
    clear_id();
    for (int i = 0; i < ADD_LAT; i++) cycle();
    set_id(0, 0, 9, 0, 0, 1, 0, 0);
    pipe_fp_write = 1; pipe_fp_dst = 7;
    first = -1; cnt_sel = 0;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      if (obs_stall && first < 0) first = i;
      if (obs_wb_sel) cnt_sel++;
    end
    check("starve_first_stall", 32'(first), 5);
    check("starve_fpu_sel", 32'(cnt_sel), 0);
    pipe_fp_write = 0;
    cycle();
    check("starve_wb_sel", obs_wb_sel, 1);
    check("starve_wb_dst", obs_wb_dst, 5);
    drain();

    // Flush beats a hazard: no stall and no issue.
    set_id(1, 1, 4, 6, 2, 1, 1, 1);
    cycle();
    set_id(1, 0, 2, 3, 8, 1, 1, 1);
    flush = 1;
    cycle();
    check("flush_stall", obs_stall, 0);
    check("flush_start", obs_start, 0);
    drain();

    // Reset during EXEC discards the op and never writes it back.
    set_id(1, 2, 0, 0, 3, 0, 0, 1);
    cycle();
    clear_id();
    cycle(); cycle(); cycle();
    #2 rst_n = 0;
    #1;
    check("arst_busy", fpu_busy, 0);
    check("arst_capture", fpu_capture, 0);
    check("arst_wb_en", wb_en, 0);
    check("arst_stall", stall, 0);
    check("arst_fpu_op", fpu_op, 0);
    model_reset();
    @(posedge clk); #1 rst_n = 1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (obs_wb_en) n++;
    end
    check("arst_no_wb", 32'(n), 0);
    set_id(0, 0, 3, 0, 0, 1, 0, 0);
    cycle();
    check("arst_f3_free", obs_stall, 0);

    // Randomized traffic; a stalled ID instruction is held until it advances.
    clear_id();
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!e_stall) begin
        set_id($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 7),
               $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        if (id_fpu_op) id_def_Fd = 1;
      end
      flush = ($urandom_range(0, 9) == 0);
      if (burst == 0 && $urandom_range(0, 40) == 0) burst = $urandom_range(5, 8);
      if (burst > 0) begin
        pipe_fp_write = 1; burst--;
      end else begin
        pipe_fp_write = ($urandom_range(0, 3) == 0);
      end
      pipe_fp_dst = 5'($urandom_range(0, 31));
      for (int t = 0; t < 8 && m_busy[pipe_fp_dst]; t++) pipe_fp_dst = 5'($urandom_range(0, 31));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
